lcd_writer: RTL and testbench
=============================

LCD_WRITER -- requirements
Module: lcd_writer

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 750000, power-on wait in clocks (15 ms at 50 MHz).
REQ-002 SHALL have parameter EN_CYC, default 12, lcd_en high time in clocks (at least 230 ns).
REQ-003 SHALL have parameter BYTE_WAIT, default 2500, post-byte wait in clocks (50 us).
REQ-004 SHALL have parameter CLEAR_WAIT, default 82000, post-clear wait in clocks (1.64 ms).
REQ-005 SHALL have port clock, input, 1 bit, single clock domain, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, request to redraw the full 32-character screen.
REQ-008 SHALL have port phrase, input, 8 bits, character byte returned by the phrase ROM bank.
REQ-009 SHALL have port addr, output, 5 bits, character index driven to the phrase ROM bank.
REQ-010 SHALL have port lcd_data, output, 8 bits, HD44780 data bus.
REQ-011 SHALL have ports lcd_rs, lcd_rw and lcd_en, outputs, 1 bit each.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 SHALL use states POWERUP, INIT, IDLE, CMD_L1, FETCH, CHAR, CMD_L2.
REQ-014 POWERUP SHALL wait POWERUP_CYC clocks, then go to INIT.
REQ-015 INIT SHALL send commands 0x38, 0x0C, 0x06, 0x01 in that order, then go to CMD_L1 (initial draw with no start needed).
REQ-016 Byte transfer: lcd_rs/lcd_data stable 1 clock, then lcd_en high EN_CYC clocks, then lcd_en low for the wait; data and rs held until the wait ends.
REQ-017 Byte wait SHALL be CLEAR_WAIT after 0x01 and BYTE_WAIT after every other byte.
REQ-018 lcd_rw SHALL be constant 0; lcd_rs SHALL be 0 for commands and 1 for characters.
REQ-019 CMD_L1 SHALL send 0x80 and clear addr to 0.
REQ-020 FETCH SHALL hold addr for exactly 1 clock (synchronous ROM latency), then go to CHAR.
REQ-021 CHAR SHALL write phrase sampled at the FETCH-to-CHAR edge, then increment addr.
REQ-022 After the char at addr 15, the block SHALL go to CMD_L2 and send 0xC0; after CMD_L2 it SHALL go to FETCH with addr 16.
REQ-023 After the char at addr 31, the block SHALL go to IDLE with addr 0; addr SHALL never wrap mid-pass.
REQ-024 start in IDLE SHALL go to CMD_L1 on the next clock.
REQ-025 start while busy SHALL set a pending flag; that flag SHALL trigger exactly one extra pass on entry to IDLE, and multiple starts SHALL collapse into one.
REQ-026 phrase changes mid-pass SHALL be reflected from the next fetched character; the block SHALL not restart the pass.

Reset
REQ-027 reset_n low at a clock edge SHALL force POWERUP, all counters 0, addr=0, lcd_data=0x00, lcd_rs=0, lcd_en=0, lcd_rw=0 and pending=0, including in the middle of a transfer.
REQ-028 busy SHALL be 1 during and after reset until IDLE is reached.

Structure
REQ-029 A shared package lcd_pkg SHALL hold the state encoding and the command constants (FUNC_SET=0x38, DISP_ON=0x0C, ENTRY=0x06, CLEAR=0x01, LINE1=0x80, LINE2=0xC0).
REQ-030 A sub-module lcd_byte_tx SHALL implement one byte transfer (inputs go, rs, byte, long_wait; output done pulse); lcd_writer SHALL sequence it.

Verification
REQ-031 The bench SHALL use POWERUP_CYC=20, EN_CYC=2, BYTE_WAIT=5 and CLEAR_WAIT=10.
REQ-032 Reset release -> exactly 20 idle clocks, then lcd_en pulses with rs=0 carrying 0x38, 0x0C, 0x06, 0x01, 0x80; gap after 0x01 equals 10 wait clocks.
REQ-033 ROM model returning 0x41+addr -> characters 0x41..0x50, then rs=0 0xC0, then 0x51..0x60, then busy falls and addr=0.
REQ-034 Two start pulses during a pass -> exactly one additional full pass, then IDLE.
REQ-035 reset_n low while lcd_en is high during char 7 -> next clock lcd_en=0, addr=0, busy=1, then full init sequence repeats.
REQ-036 Every lcd_en pulse is exactly 2 clocks wide, with lcd_data/lcd_rs unchanged from 1 clock before the rising edge until the following wait ends.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state encodings and HD44780 command bytes for the LCD writer.
package lcd_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StPowerup,
        StInit,
        StIdle,
        StCmdL1,
        StFetch,
        StChar,
        StCmdL2
    } lcd_state_e;

    // Byte transfer states
    typedef enum logic [1:0] {
        TxIdle,
        TxSetup,
        TxEn,
        TxWait
    } tx_state_e;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    // Power-on command sequence, indexed 0..3
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = FUNC_SET;
            2'd1:    cmd = DISP_ON;
            2'd2:    cmd = ENTRY;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 write: 1 setup clock, EN_CYC clocks of enable, then a settle wait.
// Data and rs stay latched until the next transfer is started.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC     = 12,
    parameter int unsigned BYTE_WAIT  = 2500,
    parameter int unsigned CLEAR_WAIT = 82000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] tx_byte,
    input  logic       long_wait,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    localparam int unsigned MaxAb  = (EN_CYC > BYTE_WAIT) ? EN_CYC : BYTE_WAIT;
    localparam int unsigned MaxCyc = (MaxAb > CLEAR_WAIT) ? MaxAb : CLEAR_WAIT;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] EnLast    = CntW'(EN_CYC - 1);
    localparam logic [CntW-1:0] ByteLast  = CntW'(BYTE_WAIT - 1);
    localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_WAIT - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            long_q, long_d;
    logic [CntW-1:0] wait_last;

    assign wait_last = long_q ? ClearLast : ByteLast;

    // Next-state: latch the byte on go, then step setup -> enable -> wait
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        long_d  = long_q;
        done    = 1'b0;
        unique case (state_q)
            TxIdle: begin
                if (go) begin
                    data_d  = tx_byte;
                    rs_d    = rs;
                    long_d  = long_wait;
                    cnt_d   = '0;
                    state_d = TxSetup;
                end
            end
            TxSetup: begin
                cnt_d   = '0;
                state_d = TxEn;
            end
            TxEn: begin
                if (cnt_q == EnLast) begin
                    cnt_d   = '0;
                    state_d = TxWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TxWait: begin
                if (cnt_q == wait_last) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = TxIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = (state_q == TxEn);

endmodule

// File: rtl/lcd_writer.sv
// Sequences power-up, LCD init and full 2x16 redraws from the phrase ROM.
module lcd_writer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned EN_CYC      = 12,
    parameter int unsigned BYTE_WAIT   = 2500,
    parameter int unsigned CLEAR_WAIT  = 82000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] phrase,
    output logic [4:0] addr,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       busy
);

    localparam int unsigned    PuW    = $clog2(POWERUP_CYC + 1);
    localparam logic [PuW-1:0] PuLast = PuW'(POWERUP_CYC - 1);

    lcd_state_e     state_q, state_d;
    logic [PuW-1:0] pu_cnt_q, pu_cnt_d;
    logic [1:0]     init_idx_q, init_idx_d;
    logic [4:0]     addr_q, addr_d;
    logic [7:0]     char_q, char_d;
    logic           issued_q, issued_d;
    logic           pending_q, pending_d;

    logic           sending;
    logic           go;
    logic           tx_rs;
    logic [7:0]     tx_byte;
    logic           long_wait;
    logic           tx_done;

    // Next-state and byte-transfer requests; each send state issues exactly one go
    always_comb begin
        state_d    = state_q;
        pu_cnt_d   = pu_cnt_q;
        init_idx_d = init_idx_q;
        addr_d     = addr_q;
        char_d     = char_q;
        issued_d   = issued_q;
        pending_d  = pending_q | (start & (state_q != StIdle));
        sending    = 1'b0;
        go         = 1'b0;
        tx_rs      = 1'b0;
        tx_byte    = 8'h00;
        long_wait  = 1'b0;
        unique case (state_q)
            StPowerup: begin
                if (pu_cnt_q == PuLast) begin
                    pu_cnt_d = '0;
                    state_d  = StInit;
                end else begin
                    pu_cnt_d = pu_cnt_q + 1'b1;
                end
            end
            StInit: begin
                sending   = 1'b1;
                tx_byte   = init_cmd(init_idx_q);
                long_wait = (tx_byte == CLEAR);
                if (tx_done) begin
                    if (init_idx_q == 2'd3) begin
                        init_idx_d = 2'd0;
                        state_d    = StCmdL1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            StIdle: begin
                if (start || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = StCmdL1;
                end
            end
            StCmdL1: begin
                sending = 1'b1;
                tx_byte = LINE1;
                addr_d  = 5'd0;
                if (tx_done) state_d = StFetch;
            end
            StFetch: begin
                // ROM output for addr is valid by the end of this clock
                char_d  = phrase;
                state_d = StChar;
            end
            StChar: begin
                sending = 1'b1;
                tx_rs   = 1'b1;
                tx_byte = char_q;
                if (tx_done) begin
                    if (addr_q == 5'd15) begin
                        addr_d  = 5'd16;
                        state_d = StCmdL2;
                    end else if (addr_q == 5'd31) begin
                        addr_d  = 5'd0;
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_q + 5'd1;
                        state_d = StFetch;
                    end
                end
            end
            StCmdL2: begin
                sending = 1'b1;
                tx_byte = LINE2;
                if (tx_done) state_d = StFetch;
            end
            default: state_d = StPowerup;
        endcase

        if (sending) begin
            go = !issued_q;
            if (tx_done) begin
                issued_d = 1'b0;
            end else if (go) begin
                issued_d = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StPowerup;
            pu_cnt_q   <= '0;
            init_idx_q <= 2'd0;
            addr_q     <= 5'd0;
            char_q     <= 8'h00;
            issued_q   <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pu_cnt_q   <= pu_cnt_d;
            init_idx_q <= init_idx_d;
            addr_q     <= addr_d;
            char_q     <= char_d;
            issued_q   <= issued_d;
            pending_q  <= pending_d;
        end
    end

    lcd_byte_tx #(
        .EN_CYC     (EN_CYC),
        .BYTE_WAIT  (BYTE_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) u_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .go        (go),
        .rs        (tx_rs),
        .tx_byte   (tx_byte),
        .long_wait (long_wait),
        .done      (tx_done),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_en    (lcd_en)
    );

    assign addr   = addr_q;
    assign lcd_rw = 1'b0;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench: stimulus pushes expected LCD writes, a monitor checks each enable pulse.
module tb_lcd_writer;

    localparam int PU = 20;
    localparam int EN = 2;
    localparam int BW = 5;
    localparam int CW = 10;

    // En-low samples before a rise: 1 issue clock + 1 setup clock after a wait,
    // plus 1 more when a FETCH or IDLE clock sits in between.
    localparam int GapCmd   = BW + 2;
    localparam int GapFetch = BW + 3;
    // After release: PU-1 power-up samples, 1 issue, 1 setup
    localparam int GapPower = PU + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] phrase;
    logic [4:0] addr;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    // Phrase ROM model: 0x41 + addr
    assign phrase = 8'h41 + {3'b000, addr};

    lcd_writer #(
        .POWERUP_CYC (PU),
        .EN_CYC      (EN),
        .BYTE_WAIT   (BW),
        .CLEAR_WAIT  (CW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .phrase   (phrase),
        .addr     (addr),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input int gap);
        exp_t e;
        e.rs   = rs;
        e.data = data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_chars();
        for (int i = 0; i < 16; i++) push(1'b1, 8'h41 + 8'(i), GapFetch);
        push(1'b0, 8'hC0, GapCmd);
        for (int i = 16; i < 32; i++) push(1'b1, 8'h41 + 8'(i), GapFetch);
    endtask

    task automatic push_init_pass();
        push(1'b0, 8'h38, GapPower);
        push(1'b0, 8'h0C, GapCmd);
        push(1'b0, 8'h06, GapCmd);
        push(1'b0, 8'h01, GapCmd);
        push(1'b0, 8'h80, CW + 2);
        push_chars();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (busy && n < budget);
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Monitor: compare every enable pulse against the scoreboard
    logic [8:0] cur, d_prev;
    logic       en_prev;
    int         hi_cnt, low_cnt, n_chg, last_chg, cyc;

    initial begin
        exp_t e;
        en_prev = 1'b0; hi_cnt = 0; low_cnt = 0; n_chg = 0; last_chg = -10; cyc = 0;
        d_prev  = '0;
        forever begin
            @(posedge clock);
            #1;
            cur = {lcd_rs, lcd_data};
            if (!reset_n) begin
                en_prev = 1'b0; hi_cnt = 0; low_cnt = 0; n_chg = 0; last_chg = -10;
                d_prev  = cur;
            end else begin
                cyc++;
                if (cur != d_prev) begin
                    n_chg++;
                    last_chg = cyc;
                end
                if (lcd_en && !en_prev) begin
                    check("rw low", {31'd0, lcd_rw}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected byte", {23'd0, cur}, 32'h1FF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte data", {24'd0, lcd_data}, {24'd0, e.data});
                        check("byte rs", {31'd0, lcd_rs}, {31'd0, e.rs});
                        if (e.gap >= 0) check("gap before byte", low_cnt, e.gap);
                    end
                    // Only allowed change since the last rise is the setup clock
                    check("data/rs stability",
                          {31'd0, (n_chg == 0) || (n_chg == 1 && last_chg == cyc - 1)}, 32'd1);
                    n_chg   = 0;
                    low_cnt = 0;
                    hi_cnt  = 1;
                end else if (lcd_en) begin
                    hi_cnt++;
                end else begin
                    if (en_prev) check("en width", hi_cnt, EN);
                    low_cnt++;
                end
                en_prev = lcd_en;
                d_prev  = cur;
            end
        end
    end

    // Stimulus
    initial begin
        int  n;
        bit  found;

        repeat (3) @(posedge clock);
        #1;
        check("reset en", {31'd0, lcd_en}, 32'd0);
        check("reset rs", {31'd0, lcd_rs}, 32'd0);
        check("reset rw", {31'd0, lcd_rw}, 32'd0);
        check("reset data", {24'd0, lcd_data}, 32'h00);
        check("reset addr", {27'd0, addr}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd1);

        // Power-up, init and automatic first draw
        push_init_pass();
        @(negedge clock);
        reset_n = 1'b1;
        wait_idle("pass1 idle", 3000);
        check("pass1 addr", {27'd0, addr}, 32'd0);

        // Start from IDLE, then two starts mid-pass collapse into one extra pass
        push(1'b0, 8'h80, -1);
        push_chars();
        pulse_start();
        repeat (60) @(negedge clock);
        push(1'b0, 8'h80, GapFetch);
        push_chars();
        pulse_start();
        repeat (40) @(negedge clock);
        pulse_start();
        wait_idle("pass2 idle", 3000);
        @(posedge clock);
        #1;
        check("pending pass starts", {31'd0, busy}, 32'd1);
        wait_idle("pass3 idle", 3000);
        repeat (60) @(posedge clock);
        #1;
        check("no extra pass", {31'd0, busy}, 32'd0);
        check("queue drained", exp_q.size(), 32'd0);

        // Reset while enable is high on char 7
        push(1'b0, 8'h80, -1);
        for (int i = 0; i < 8; i++) push(1'b1, 8'h41 + 8'(i), GapFetch);
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
            found = (addr == 5'd7) && lcd_en && lcd_rs;
        end
        check("char7 pulse seen", {31'd0, found}, 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midreset en", {31'd0, lcd_en}, 32'd0);
        check("midreset addr", {27'd0, addr}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd1);
        check("midreset data", {24'd0, lcd_data}, 32'h00);
        check("midreset queue", exp_q.size(), 32'd0);
        push_init_pass();
        @(negedge clock);
        reset_n = 1'b1;
        wait_idle("reinit idle", 3000);
        repeat (20) @(posedge clock);
        #1;
        check("final addr", {27'd0, addr}, 32'd0);
        check("final queue", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
